// File: rtl/jt49_cendiv.sv
// Clock-enable divider chain: a programmable prescaler feeding a binary stage
// counter, producing one-cycle enable pulses at base/(R*2^k) for each stage k.
module jt49_cendiv #(
  parameter int STAGES = 4,
  parameter int PRE_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic [PRE_W-1:0]  div,
  input  logic              sync,
  output logic [STAGES-1:0] cen_out,
  output logic [STAGES-2:0] phase
);

  localparam int CW = STAGES - 1;

  logic [PRE_W-1:0]  pcnt_q, pcnt_d;
  logic [PRE_W-1:0]  div_lat_q, div_lat_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [STAGES-1:0] cen_out_q, cen_out_d;
  logic [STAGES-1:0] stage_hit;
  logic              evt, wrap;

  // Stage k fires on the event that carries out of the low k counter bits.
  assign stage_hit[0] = 1'b1;
  generate
    for (genvar k = 1; k < STAGES; k++) begin : g_hit
      assign stage_hit[k] = &cnt_q[k-1:0];
    end
  endgenerate

  assign evt  = cen & ~sync & (pcnt_q == div_lat_q);
  assign wrap = evt & (&cnt_q);

  always_comb begin
    pcnt_d    = pcnt_q;
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    cen_out_d = '0;
    if (sync) begin
      pcnt_d    = '0;
      cnt_d     = '0;
      div_lat_d = div;
    end else if (cen) begin
      if (evt) begin
        pcnt_d    = '0;
        cnt_d     = cnt_q + 1'b1;
        cen_out_d = stage_hit;
        // Divisor only retimes at a full-chain wrap so every stage stays aligned.
        if (wrap) div_lat_d = div;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q    <= '0;
      cnt_q     <= '0;
      div_lat_q <= div;
      cen_out_q <= '0;
    end else begin
      pcnt_q    <= pcnt_d;
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      cen_out_q <= cen_out_d;
    end
  end

  assign cen_out = cen_out_q;
  assign phase   = cnt_q;

endmodule

// File: tb/tb_jt49_cendiv.sv
// Scoreboard bench for jt49_cendiv: a behavioural event-count model pushes
// expected outputs per driven cycle; they are popped and compared after the edge.
module tb_jt49_cendiv;

  logic       clk = 1'b0;
  logic       rst = 1'b0, cen = 1'b0, sync = 1'b0;
  logic [3:0] div = '0;
  logic [3:0] cen_out;
  logic [2:0] phase;

  jt49_cendiv #(.STAGES(4), .PRE_W(4)) dut (
    .clk(clk), .rst(rst), .cen(cen), .div(div), .sync(sync),
    .cen_out(cen_out), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] co; logic [2:0] ph; } exp_t;
  exp_t sb_q[$];

  int n_chk = 0, n_fail = 0;
  int m_pre = 0, m_ev = 0, m_div = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: m_ev counts events since restart; stage k pulses when that count
  // reaches a multiple of 2^k.
  task automatic step(input logic c, input logic s, input logic r, input logic [3:0] d);
    exp_t e;
    logic [3:0] ex;
    cen = c; sync = s; rst = r; div = d;
    ex = '0;
    if (r || s) begin
      m_pre = 0; m_ev = 0; m_div = int'(d);
    end else if (c) begin
      if (m_pre == m_div) begin
        ex[0] = 1'b1;
        for (int k = 1; k < 4; k++)
          if (((m_ev + 1) % (1 << k)) == 0) ex[k] = 1'b1;
        if (m_ev == 7) m_div = int'(d);
        m_ev  = (m_ev + 1) % 8;
        m_pre = 0;
      end else begin
        m_pre++;
      end
    end
    e.co = ex;
    e.ph = 3'(m_ev);
    sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk("cen_out", 32'(cen_out), 32'(e.co));
    chk("phase", 32'(phase), 32'(e.ph));
  endtask

  task automatic run_until_ev(input int ev, input int pre, input logic [3:0] d, input string tag);
    int n;
    n = 0;
    while (!(m_ev == ev && (pre < 0 || m_pre == pre)) && n < 200) begin
      step(1'b1, 1'b0, 1'b0, d);
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  initial begin
    int pulses;
    logic [3:0] rd;

    // Reset state, then div=0 free-running
    step(1'b0, 1'b0, 1'b1, 4'd0);
    chk("rst_cen_out", 32'(cen_out), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0);
      if (cen_out[3]) pulses++;
    end
    chk("div0_stage3_cnt", 32'(pulses), 32'd2);

    // div=2 with cen toggling: stage0 every 6 clk
    step(1'b0, 1'b0, 1'b1, 4'd2);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      step(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0, 4'd2);
      if (cen_out[0]) pulses++;
    end
    chk("div2_toggle_cnt", 32'(pulses), 32'd4);

    // Divisor change mid-chain waits for the wrap
    run_until_ev(3, -1, 4'd2, "div_chg");
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("div_chg_after", 32'(cen_out[0]), 32'd1);

    // Sync with cen=1 at phase 5
    step(1'b0, 1'b0, 1'b1, 4'd2);
    run_until_ev(5, -1, 4'd2, "sync");
    step(1'b1, 1'b1, 1'b0, 4'd0);
    chk("sync_cen_out", 32'(cen_out), 32'd0);
    chk("sync_phase", 32'(phase), 32'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("sync_first", 32'(cen_out), 32'b0001);

    // Reset mid-period at phase 6, pcnt 1
    step(1'b0, 1'b1, 1'b0, 4'd2);
    run_until_ev(6, 1, 4'd2, "midrst");
    step(1'b1, 1'b0, 1'b1, 4'd2);
    chk("midrst_phase", 32'(phase), 32'd0);
    step(1'b1, 1'b0, 1'b0, 4'd2);
    chk("post_rst_none", 32'(cen_out), 32'd0);

    // cen held low mid-period
    run_until_ev(2, 1, 4'd2, "hold");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 4'd2);
    chk("hold_phase", 32'(phase), 32'd2);
    step(1'b1, 1'b0, 1'b0, 4'd2);
    step(1'b1, 1'b0, 1'b0, 4'd2);
    chk("hold_resume", 32'(phase), 32'd3);

    // Max divisor and random traffic
    step(1'b0, 1'b1, 1'b0, 4'd15);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 4'd15);
    rd = 4'd1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) rd = 4'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 60) == 0, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jt49_cendiv.md
JT49_CENDIV -- requirements
Module: jt49_cendiv

Interface
REQ-001 Parameter STAGES, default 4, number of clock-enable outputs; legal range 2..8.
REQ-002 Parameter PRE_W, default 4, prescaler divisor width; legal range 1..8.
REQ-003 Port clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous reset, active-high.
REQ-005 Port cen  input  1  base clock enable; events counted only when high.
REQ-006 Port div  input  PRE_W  prescale divisor minus one; ratio R = div+1 (1..2^PRE_W).
REQ-007 Port sync  input  1  synchronous restart of the divider chain.
REQ-008 Port cen_out  output  STAGES  one-cycle enable pulses; bit k rate = base/(R*2^k).
REQ-009 Port phase  output  STAGES-1  current binary stage count, for alignment and debug.

Function
REQ-010 Internal state SHALL be: prescaler count pcnt (PRE_W bits), stage count cnt (STAGES-1 bits), latched divisor div_lat (PRE_W bits).
REQ-011 An event SHALL occur in a cycle where cen=1, sync=0 and pcnt==div_lat.
REQ-012 With cen=1, sync=0 and no event, pcnt SHALL increment by one; on an event pcnt SHALL return to 0.
REQ-013 With cen=0 and sync=0, pcnt, cnt and div_lat SHALL hold, and cen_out SHALL be 0 next cycle.
REQ-014 On an event, cnt SHALL increment modulo 2^(STAGES-1).
REQ-015 cen_out[0] SHALL be 1 in the cycle after every event.
REQ-016 cen_out[k], k>=1, SHALL be 1 in the cycle after an event in which cnt[k-1:0] is all ones; otherwise 0.
REQ-017 cen_out SHALL be registered: latency exactly one clk from the qualifying cen cycle; every pulse is exactly one cycle wide.
REQ-018 div_lat SHALL load div only at reset, on sync, or on a wrap event (event with cnt all ones); div changes at other times SHALL NOT affect the current period.
REQ-019 On a wrap event, the new div_lat SHALL govern counting from the next cycle on.
REQ-020 sync=1 SHALL set pcnt=0, cnt=0, div_lat=div and cen_out=0 next cycle, taking priority over cen.
REQ-021 After sync or reset, the first event SHALL drive only cen_out[0]; cen_out[k] first fires on the 2^k-th event.
REQ-022 phase SHALL equal cnt, combinationally from the register.
REQ-023 div=0 SHALL give R=1: every cen cycle is an event.
REQ-024 If div_lat's maximum is reached, pcnt SHALL compare equal and wrap without overflow past 2^PRE_W-1.

Reset
REQ-025 rst=1 SHALL, at the next rising edge, set cen_out=0, pcnt=0, cnt=0, div_lat=div; rst takes priority over sync and cen.
REQ-026 rst asserted mid-period SHALL discard partial counts; no pulse SHALL be emitted in the cycle following reset.

Verification
REQ-027 STAGES=4, PRE_W=4, div=0, cen=1 constant after rst release -> cen_out[0] every cycle; [1] every 2nd cycle, first on the 2nd pulse; [3] every 8th cycle, first on the 8th pulse.
REQ-028 div=2, cen toggling 1,0,1,0 -> cen_out[0] pulse every 6 clk, each one cycle wide; cen_out[1] every 12 clk.
REQ-029 div=2 running, change div to 0 when phase=3 -> period stays 3 events until the event with phase=7; thereafter cen_out[0] follows every cen.
REQ-030 sync=1 with cen=1 and phase=5 -> cen_out=0 next cycle, phase=0; the following cen cycle with div=0 yields cen_out=4'b0001.
REQ-031 rst=1 for one cycle with phase=6 and pcnt=1 -> cen_out=0, phase=0 next cycle; no pulse in the cycle after rst falls.
REQ-032 cen=0 held 20 cycles mid-period -> no pulses, phase and pcnt frozen; counting resumes from the same values when cen returns.
